// File: rtl/lcd_char_driver.sv
// HD44780 16x2 driver: power-up wait, 4-command init, then endless two-line refresh from an indexed text source.
// Define LCD_FRAME_GAP_EN to idle FRAME_GAP_CYC clocks between frames; otherwise line 1 restarts right after frame_done.
module lcd_char_driver #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000,
    parameter int unsigned FRAME_GAP_CYC  = 500000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] char_in_i,
    output logic [4:0] index_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic [7:0] lcd_data_o,
    output logic       init_done_o,
    output logic       frame_done_o
);

`ifdef LCD_FRAME_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FRAME_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(1);

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT,
        OP_ADDR1,
        OP_CHAR,
        OP_ADDR2
    } op_t;

    state_t           state_q;
    op_t              op_q;
    logic [1:0]       init_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       index_q;
    logic             rs_q;
    logic             en_q;
    logic [7:0]       data_q;
    logic             init_done_q;
    logic             frame_done_q;

    logic [7:0]       next_init_d;
    logic [CNT_W-1:0] hold_last_d;

    // Only the clear command needs the long settle time.
    always_comb begin
        next_init_d = CMD_CLEAR;
        case (init_idx_q)
            2'd0:    next_init_d = CMD_DISP;
            2'd1:    next_init_d = CMD_ENTRY;
            default: next_init_d = CMD_CLEAR;
        endcase
        hold_last_d = CMD_LAST;
        if (op_q == OP_INIT && init_idx_q == 2'd3) begin
            hold_last_d = CLEAR_LAST;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_PWRUP;
            op_q         <= OP_INIT;
            init_idx_q   <= '0;
            cnt_q        <= '0;
            index_q      <= '0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            data_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cnt_q        <= cnt_q + CNT_W'(1);
            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == PWRUP_LAST) begin
                        state_q    <= S_SETUP;
                        cnt_q      <= '0;
                        op_q       <= OP_INIT;
                        init_idx_q <= '0;
                        rs_q       <= 1'b0;
                        data_q     <= CMD_FUNC;
                    end
                end
                // index_q was updated on entry; the source answers one clock later.
                S_FETCH: begin
                    if (cnt_q == FETCH_LAST) begin
                        state_q <= S_SETUP;
                        cnt_q   <= '0;
                        rs_q    <= 1'b1;
                        data_q  <= char_in_i;
                    end
                end
                S_SETUP: begin
                    state_q <= S_PULSE;
                    cnt_q   <= '0;
                    en_q    <= 1'b1;
                end
                S_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == hold_last_d) begin
                        cnt_q <= '0;
                        case (op_q)
                            OP_INIT: begin
                                state_q <= S_SETUP;
                                rs_q    <= 1'b0;
                                if (init_idx_q == 2'd3) begin
                                    init_done_q <= 1'b1;
                                    op_q        <= OP_ADDR1;
                                    data_q      <= CMD_LINE1;
                                end else begin
                                    init_idx_q <= init_idx_q + 2'd1;
                                    data_q     <= next_init_d;
                                end
                            end
                            OP_ADDR1: begin
                                state_q <= S_FETCH;
                                op_q    <= OP_CHAR;
                                index_q <= 5'd0;
                            end
                            OP_ADDR2: begin
                                state_q <= S_FETCH;
                                op_q    <= OP_CHAR;
                                index_q <= 5'd16;
                            end
                            default: begin
                                if (index_q == 5'd15) begin
                                    state_q <= S_SETUP;
                                    op_q    <= OP_ADDR2;
                                    rs_q    <= 1'b0;
                                    data_q  <= CMD_LINE2;
                                end else if (index_q == 5'd31) begin
                                    frame_done_q <= 1'b1;
                                    index_q      <= 5'd0;
                                    if (GAP_EN) begin
                                        state_q <= S_GAP;
                                    end else begin
                                        state_q <= S_SETUP;
                                        op_q    <= OP_ADDR1;
                                        rs_q    <= 1'b0;
                                        data_q  <= CMD_LINE1;
                                    end
                                end else begin
                                    state_q <= S_FETCH;
                                    index_q <= index_q + 5'd1;
                                end
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_SETUP;
                        cnt_q   <= '0;
                        op_q    <= OP_ADDR1;
                        rs_q    <= 1'b0;
                        data_q  <= CMD_LINE1;
                    end
                end
                default: begin
                    state_q <= S_PWRUP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign index_o      = index_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_rw_o     = 1'b0;
    assign lcd_en_o     = en_q;
    assign lcd_data_o   = data_q;
    assign init_done_o  = init_done_q;
    assign frame_done_o = frame_done_q;

endmodule
